// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin sharing of one single-port RAM between three requesters
module ram_access_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  interrupt,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_W-1:0]     ram_rdata
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0] state, last, first, second, pick;
    logic [2:0] latCnt;

    // search starts at the port after the previous owner; the previous owner comes last
    always_comb begin
        first = (last == 2'd2) ? 2'd0 : last + 2'd1;
        second = (first == 2'd2) ? 2'd0 : first + 2'd1;
        pick = req[first] ? first : req[second] ? second : last;
    end

    // transaction sequencer: grant and strobe, wait out read latency, pulse done, release
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            last <= 2'd2;
            owner <= 2'd3;
            gnt <= '0;
            done <= '0;
            busy <= 1'b0;
            rdata <= '0;
            ram_addr <= '0;
            ram_wdata <= '0;
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            latCnt <= '0;
        end else if (interrupt && (state == ACCESS || state == WAIT)) begin
            state <= IDLE;
            owner <= 2'd3;
            gnt <= '0;
            busy <= 1'b0;
            ram_we <= 1'b0;
            ram_re <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!interrupt && req != 3'b000) begin
                    state <= ACCESS;
                    last <= pick;
                    owner <= pick;
                    gnt <= 3'b001 << pick;
                    busy <= 1'b1;
                    ram_addr <= addr[pick*ADDR_W +: ADDR_W];
                    ram_wdata <= wdata[pick*DATA_W +: DATA_W];
                    ram_we <= we[pick];
                    ram_re <= !we[pick];
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                    ram_re <= 1'b0;
                    latCnt <= 3'(RD_LAT);
                    state <= ram_we ? DONE : WAIT;
                    done <= ram_we ? gnt : 3'b000;
                end
                WAIT: if (latCnt == 3'd1) begin
                    rdata <= ram_rdata;
                    done <= gnt;
                    state <= DONE;
                end else begin
                    latCnt <= latCnt - 3'd1;
                end
                default: begin
                    done <= '0;
                    gnt <= '0;
                    owner <= 2'd3;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized scoreboard bench with a transaction-level round-robin model
module tb_ram_access_arbiter;
    localparam int AW = 16, DW = 8, LAT = 3;

    typedef struct {
        int         port;
        bit         isRead;
        logic [7:0] data;
        int         doneCyc;
    } expT;

    logic clk, RST, interrupt;
    logic [2:0] req, we, gnt, done;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [DW-1:0] rdata, ramWdata, ramRdata;
    logic busy, ramWe, ramRe;
    logic [1:0] owner;
    logic [AW-1:0] ramAddr;

    logic [2:0] reqB, weB, gntB, doneB;
    logic [3*AW-1:0] addrB;
    logic [3*DW-1:0] wdataB;
    logic [DW-1:0] rdataB, ramWdataB, ramRdataB;
    logic busyB, ramWeB, ramReB;
    logic [1:0] ownerB;
    logic [AW-1:0] ramAddrB;

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dutA (
        .clk(clk), .RST(RST), .interrupt(interrupt), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .owner(owner), .ram_addr(ramAddr),
        .ram_wdata(ramWdata), .ram_we(ramWe), .ram_re(ramRe), .ram_rdata(ramRdata)
    );

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dutB (
        .clk(clk), .RST(RST), .interrupt(1'b0), .req(reqB), .we(weB), .addr(addrB), .wdata(wdataB),
        .gnt(gntB), .done(doneB), .rdata(rdataB), .busy(busyB), .owner(ownerB), .ram_addr(ramAddrB),
        .ram_wdata(ramWdataB), .ram_we(ramWeB), .ram_re(ramReB), .ram_rdata(ramRdataB)
    );

    int cyc = 0;
    int nChk = 0, nPass = 0;
    expT sb[$];

    int lastRef;
    logic [7:0] refMem [logic [15:0]];
    int cnt[3], off[3];
    bit opW[3];
    logic [15:0] pa[3];
    logic [7:0] pd[3];

    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a[7:0] + 8'h1C;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM behind dutA: untouched locations read as initVal, data appears LAT cycles after the strobe
    logic [7:0] mem [0:65535];
    bit wr [0:65535];
    logic [7:0] pipe [LAT];
    assign ramRdata = pipe[LAT-1];
    always @(posedge clk) begin
        if (ramWe) begin
            mem[ramAddr] <= ramWdata;
            wr[ramAddr] <= 1'b1;
        end
        pipe[0] <= ramRe ? (wr[ramAddr] ? mem[ramAddr] : initVal(ramAddr)) : 8'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // read-only RAM behind dutB with single-cycle latency
    always @(posedge clk) ramRdataB <= ramReB ? initVal(ramAddrB) : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // monitor: every done pulse must match the next expected completion
    always @(negedge clk) begin
        expT e;
        if (!RST && done != 3'b000) begin
            if (sb.size() == 0) chk("unexpectedDone", 32'(done), 32'd0);
            else begin
                e = sb.pop_front();
                chk("donePort", 32'(done), 32'(3'b001 << e.port));
                chk("doneCycle", cyc, e.doneCyc);
                chk("gntInDone", 32'(gnt), 32'(3'b001 << e.port));
                if (e.isRead) chk("rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    function automatic logic [7:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    // reference: grant ports in round robin among those still requesting, one serial transaction at a time
    task automatic modelBatch(input int e0);
        int rem[3];
        int t, p, c;
        expT e;
        t = e0;
        rem = cnt;
        while (rem[0] + rem[1] + rem[2] > 0) begin
            p = -1;
            for (int j = 1; j <= 3; j++) begin
                c = (lastRef + j) % 3;
                if (p < 0 && rem[c] > 0 && e0 + off[c] <= t) p = c;
            end
            if (p < 0) t++;
            else begin
                lastRef = p;
                rem[p]--;
                e.port = p;
                e.isRead = !opW[p];
                e.data = refRead(pa[p]);
                if (opW[p]) refMem[pa[p]] = pd[p];
                e.doneCyc = t + 1 + (opW[p] ? 0 : LAT);
                sb.push_back(e);
                t = e.doneCyc + 2;
            end
        end
    endtask

    // drive a batch from an IDLE-cycle negedge; ports hold req until their last done
    task automatic runBatch();
        int rem[3];
        int e0;
        e0 = cyc + 1;
        rem = cnt;
        modelBatch(e0);
        for (int k = 0; k < 400 && rem[0] + rem[1] + rem[2] > 0; k++) begin
            for (int i = 0; i < 3; i++) if (rem[i] > 0 && cyc + 1 - e0 >= off[i]) begin
                req[i] = 1'b1;
                we[i] = opW[i];
                addr[i*AW +: AW] = pa[i];
                wdata[i*DW +: DW] = pd[i];
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
            end
        end
        chk("batchRemaining", rem[0] + rem[1] + rem[2], 0);
        req = '0;
        @(negedge clk);
    endtask

    task automatic doReset();
        RST = 1'b1;
        req = '0;
        reqB = '0;
        interrupt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        lastRef = 2;
    endtask

    task automatic checkResetVals(input string tag);
        chk({tag, "Gnt"}, 32'(gnt), 32'd0);
        chk({tag, "Done"}, 32'(done), 32'd0);
        chk({tag, "Busy"}, 32'(busy), 32'd0);
        chk({tag, "Owner"}, 32'(owner), 32'd3);
        chk({tag, "RamWe"}, 32'(ramWe), 32'd0);
        chk({tag, "RamRe"}, 32'(ramRe), 32'd0);
        chk({tag, "Rdata"}, 32'(rdata), 32'd0);
        chk({tag, "RamAddr"}, 32'(ramAddr), 32'd0);
        chk({tag, "RamWdata"}, 32'(ramWdata), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int eB;
        we = '0; addr = '0; wdata = '0;
        weB = '0; addrB = '0; wdataB = '0;
        doReset();
        checkResetVals("reset");

        // single write by port 1
        cnt = '{0, 1, 0}; off = '{0, 0, 0}; opW = '{0, 1, 0}; pa[1] = 16'h0010; pd[1] = 8'hA5;
        modelBatch(cyc + 1);
        req = 3'b010; we = 3'b010; addr[AW +: AW] = 16'h0010; wdata[DW +: DW] = 8'hA5;
        @(negedge clk);
        chk("t1Gnt", 32'(gnt), 32'b010);
        chk("t1Owner", 32'(owner), 32'd1);
        chk("t1RamWe", 32'(ramWe), 32'd1);
        chk("t1RamRe", 32'(ramRe), 32'd0);
        chk("t1RamAddr", 32'(ramAddr), 32'h10);
        chk("t1RamWdata", 32'(ramWdata), 32'hA5);
        chk("t1Busy", 32'(busy), 32'd1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("t1BusyAfter", 32'(busy), 32'd0);
        chk("t1OwnerAfter", 32'(owner), 32'd3);
        chk("t1GntAfter", 32'(gnt), 32'd0);

        // single-cycle read latency on dutB
        reqB = 3'b001; weB = 3'b000; addrB[0 +: AW] = 16'h0020;
        eB = cyc + 1;
        @(negedge clk);
        chk("bRamRe", 32'(ramReB), 32'd1);
        chk("bRamWe", 32'(ramWeB), 32'd0);
        chk("bRamAddr", 32'(ramAddrB), 32'h20);
        chk("bRamWdata", 32'(ramWdataB), 32'd0);
        chk("bOwner", 32'(ownerB), 32'd0);
        for (int k = 0; k < 10 && doneB == 3'b000; k++) @(negedge clk);
        chk("bDone", 32'(doneB), 32'b001);
        chk("bGnt", 32'(gntB), 32'b001);
        chk("bDoneCycle", cyc, eB + 2);
        chk("bRdata", 32'(rdataB), 32'h3C);
        reqB = '0;
        @(negedge clk);
        chk("bBusyAfter", 32'(busyB), 32'd0);

        // three-cycle read latency on dutA
        cnt = '{1, 0, 0}; opW = '{0, 0, 0}; pa[0] = 16'h0020;
        runBatch();

        // all three held, all writes: strict 0,1,2,0,1,2
        doReset();
        cnt = '{2, 2, 2}; off = '{0, 0, 0}; opW = '{1, 1, 1};
        pa = '{16'h1, 16'h2, 16'h3}; pd = '{8'h11, 8'h22, 8'h33};
        runBatch();

        // port 0 held, port 2 joins while port 0 owns the RAM
        cnt = '{2, 0, 2}; off = '{0, 0, 1}; opW = '{1, 0, 0};
        pa = '{16'h4, 16'h0, 16'h2}; pd = '{8'h44, 8'h00, 8'h00};
        runBatch();

        // interrupt during a port 2 read wait
        off = '{0, 0, 0};
        req = 3'b100; we = 3'b000; addr[2*AW +: AW] = 16'h0005;
        lastRef = 2;
        @(negedge clk);
        @(negedge clk);
        interrupt = 1'b1;
        @(negedge clk);
        interrupt = 1'b0;
        req = '0;
        chk("intGnt", 32'(gnt), 32'd0);
        chk("intBusy", 32'(busy), 32'd0);
        chk("intOwner", 32'(owner), 32'd3);
        chk("intRamRe", 32'(ramRe), 32'd0);
        repeat (6) @(negedge clk);
        cnt = '{0, 1, 0}; opW = '{0, 1, 0}; pa[1] = 16'h0006; pd[1] = 8'h5E;
        runBatch();

        // interrupt held in IDLE blocks any grant
        interrupt = 1'b1;
        req = 3'b001; we = 3'b001; addr[0 +: AW] = 16'h0007; wdata[0 +: DW] = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("idleIntGnt", 32'(gnt), 32'd0);
            chk("idleIntBusy", 32'(busy), 32'd0);
        end
        interrupt = 1'b0;
        cnt = '{1, 0, 0}; opW = '{1, 0, 0}; pa[0] = 16'h0007; pd[0] = 8'h77;
        runBatch();

        // reset during a port 1 read access
        req = 3'b010; we = 3'b000; addr[AW +: AW] = 16'h000A;
        @(negedge clk);
        chk("rstRamRe", 32'(ramRe), 32'd1);
        RST = 1'b1;
        @(negedge clk);
        checkResetVals("midRst");
        RST = 1'b0;
        req = '0;
        lastRef = 2;
        cnt = '{0, 1, 1}; opW = '{0, 0, 1}; pa = '{16'h0, 16'h0010, 16'h0008}; pd = '{8'h0, 8'h0, 8'h88};
        runBatch();

        // randomized batches
        repeat (30) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] = $urandom_range(0, 2);
                off[i] = $urandom_range(0, 3);
                opW[i] = 1'($urandom_range(0, 1));
                pa[i] = 16'($urandom_range(0, 15));
                pd[i] = 8'($urandom);
            end
            if (cnt[0] + cnt[1] + cnt[2] == 0) cnt[$urandom_range(0, 2)] = 1;
            runBatch();
        end

        repeat (4) @(negedge clk);
        chk("scoreboardEmpty", sb.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
